// File: rtl/hazard_stall_unit.sv
// Pipeline hold/flush controller: load-use stall, taken-branch flush, mul/div EX occupancy,
// plus a saturating count of cycles in which the PC was held.
module hazard_stall_unit #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_MulDiv,
  input  logic             branch_taken,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, MULDIV_BUSY} state_t;

  localparam int            CW      = 5;
  localparam logic [CW-1:0] MD_LOAD = CW'(MULDIV_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lu;
  logic          go_busy;

  assign lu = EX_MemRead && (EX_rd != 5'd0) &&
              ((EX_rd == ID_rs) || (ID_uses_rt && (EX_rd == ID_rt)));

  always_comb begin
    // NOTE: every output gets its default first so no path can infer a latch.
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    go_busy      = 1'b0;

    if (rst) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Bubble  = 1'b1;
      EXMEM_Bubble = 1'b1;
    end else if (state == MULDIV_BUSY) begin
      // Only cnt matters here, so garbage on the hazard inputs cannot leak out.
      if (cnt > CW'(1)) begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
      end
    end else if (branch_taken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (EX_MulDiv) begin
      if (MULDIV_CYCLES > 1) begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
        go_busy      = 1'b1;
      end
    end else if (lu) begin
      // IDEX_Write stays high so the NOP actually lands in ID/EX.
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      busy        <= 1'b0;
      stall_count <= '0;
    end else begin
      if (!PCWrite && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;

      case (state)
        RUN: begin
          if (go_busy) begin
            state <= MULDIV_BUSY;
            cnt   <= MD_LOAD;
            busy  <= 1'b1;
          end
        end
        MULDIV_BUSY: begin
          if (cnt > CW'(1)) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: a cycle-indexed model of mul/div occupancy and hazard rules
// checked every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_hazard_stall_unit;

  localparam int MC      = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic pcw, ifidw, flush, idexw, bub, exbub;
  } ctl_t;

  localparam ctl_t C_DEF = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t C_RST = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam ctl_t C_FRZ = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctl_t C_BR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctl_t C_LU  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       ID_rs, ID_rt, EX_rd;
  logic             ID_uses_rt, EX_MemRead, EX_MulDiv, branch_taken;
  logic             PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble;
  logic             busy;
  logic [CNT_W-1:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  hazard_stall_unit #(.MULDIV_CYCLES(MC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_rd(EX_rd), .EX_MemRead(EX_MemRead), .EX_MulDiv(EX_MulDiv),
    .branch_taken(branch_taken),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble),
    .busy(busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Model: prev_md is the position (1..MC) of the mul/div that was in EX last cycle, 0 if none.
  int prev_md = 0;
  int m_count = 0;
  bit m_valid = 1'b0;

  function automatic int cur_md();
    if (prev_md >= 1 && prev_md < MC) return prev_md + 1;
    if (EX_MulDiv === 1'b1 && branch_taken !== 1'b1 && MC > 1) return 1;
    return 0;
  endfunction

  function automatic ctl_t exp_ctl();
    int md;
    logic lu;
    md = cur_md();
    if (rst) return C_RST;
    if (md >= 1 && md < MC) return C_FRZ;
    if (md == MC) return C_DEF;
    if (branch_taken) return C_BR;
    if (EX_MulDiv) return C_DEF;
    lu = EX_MemRead && EX_rd != 0 && (EX_rd == ID_rs || (ID_uses_rt && EX_rd == ID_rt));
    return lu ? C_LU : C_DEF;
  endfunction

  always @(posedge clk) begin
    ctl_t e;
    if (rst) begin
      prev_md <= 0;
      m_count <= 0;
      m_valid <= 1'b1;
    end else begin
      e = exp_ctl();
      prev_md <= cur_md();
      if (!e.pcw && m_count < CNT_MAX) m_count <= m_count + 1;
    end
  end

  always @(negedge clk) begin
    ctl_t e;
    if (m_valid) begin
      e = exp_ctl();
      check("PCWrite",      PCWrite,      e.pcw);
      check("IFID_Write",   IFID_Write,   e.ifidw);
      check("IFID_Flush",   IFID_Flush,   e.flush);
      check("IDEX_Write",   IDEX_Write,   e.idexw);
      check("IDEX_Bubble",  IDEX_Bubble,  e.bub);
      check("EXMEM_Bubble", EXMEM_Bubble, e.exbub);
      check("busy",         busy,         (cur_md() >= 2) ? 1 : 0);
      check("stall_count",  stall_count,  m_count);
    end
  end

  // Apply one cycle of inputs just after the edge, return at the following negedge.
  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                       input logic [4:0] rd, input logic mr, input logic md, input logic br);
    @(posedge clk);
    #1;
    rst = r; ID_rs = rs; ID_rt = rt; ID_uses_rt = use_rt;
    EX_rd = rd; EX_MemRead = mr; EX_MulDiv = md; branch_taken = br;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ID_rs = '0; ID_rt = '0; ID_uses_rt = 1'b0;
    EX_rd = '0; EX_MemRead = 1'b0; EX_MulDiv = 1'b0; branch_taken = 1'b0;

    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_PCWrite", PCWrite, 0);
    check("rst_Flush", IFID_Flush, 1);
    check("rst_EXMEM_Bubble", EXMEM_Bubble, 1);
    idle();
    check("post_rst_count", stall_count, 0);
    check("post_rst_busy", busy, 0);

    // Load-use on rs
    drive(1'b0, 5'd5, 5'd9, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    check("lu_PCWrite", PCWrite, 0);
    check("lu_IDEX_Bubble", IDEX_Bubble, 1);
    check("lu_IDEX_Write", IDEX_Write, 1);
    idle();
    check("lu_after_PCWrite", PCWrite, 1);
    check("lu_count", stall_count, 1);

    // rt gating and register 0
    drive(1'b0, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    check("rt_unused_PCWrite", PCWrite, 1);
    drive(1'b0, 5'd0, 5'd4, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    check("zero_reg_PCWrite", PCWrite, 1);
    drive(1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    check("rt_used_PCWrite", PCWrite, 0);
    idle();
    check("rt_count", stall_count, 2);

    // Mul/div held 4 cycles; hazard inputs are X while EX is occupied
    drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    check("md1_PCWrite", PCWrite, 0);
    check("md1_EXMEM_Bubble", EXMEM_Bubble, 1);
    check("md1_busy", busy, 0);
    drive(1'b0, 'x, 'x, 1'bx, 'x, 1'bx, 1'b1, 1'b0);
    check("md2_busy", busy, 1);
    drive(1'b0, 'x, 'x, 1'bx, 'x, 1'bx, 1'b1, 1'b0);
    drive(1'b0, 'x, 'x, 1'bx, 'x, 1'bx, 1'b1, 1'b0);
    check("md4_PCWrite", PCWrite, 1);
    check("md4_busy", busy, 1);
    idle();
    check("md_after_busy", busy, 0);
    check("md_count", stall_count, 5);

    // Branch beats load-use
    drive(1'b0, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    check("br_Flush", IFID_Flush, 1);
    check("br_IDEX_Bubble", IDEX_Bubble, 1);
    check("br_PCWrite", PCWrite, 1);
    idle();
    check("br_count", stall_count, 5);

    // Back-to-back mul/div: cycle 5 restarts immediately
    for (int i = 1; i <= 2 * MC; i++) begin
      drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
      if (i == MC + 1) begin
        check("b2b_restart_PCWrite", PCWrite, 0);
        check("b2b_restart_busy", busy, 0);
      end
    end
    idle();
    check("b2b_count", stall_count, 11);

    // Reset on cycle 2 of a mul/div
    drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    check("mdrst_PCWrite", PCWrite, 0);
    check("mdrst_IDEX_Write", IDEX_Write, 0);
    check("mdrst_IDEX_Bubble", IDEX_Bubble, 1);
    idle();
    check("mdrst_busy", busy, 0);
    check("mdrst_count", stall_count, 0);
    check("mdrst_PCWrite_after", PCWrite, 1);

    // Saturation
    for (int i = 0; i < 20; i++)
      drive(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    idle();
    check("sat_count", stall_count, 15);

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Pipeline hold/flush controller for the 5-stage CPU. It sits beside the forwarding logic. Forwarding resolves data hazards by steering operands toward EX. This block handles the hazards forwarding cannot cover: load-use, taken-branch flush in EX, and multi-cycle mul/div occupancy of EX. It drives the PC and pipeline-register write enables and bubble controls, and keeps a saturating stall-cycle counter.

Parameters:
MULDIV_CYCLES, 4, total cycles a mul/div occupies EX (legal range 1..16; 1 means no stall)
CNT_W, 16, width of stall_count

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
ID_rs  input  5  rs field of instruction in ID
ID_rt  input  5  rt field of instruction in ID
ID_uses_rt  input  1  ID instruction reads rt as a source
EX_rd  input  5  destination register of instruction in EX
EX_MemRead  input  1  EX instruction is a load
EX_MulDiv  input  1  EX instruction is mul/div
branch_taken  input  1  branch resolved taken in EX this cycle
PCWrite  output  1  PC update enable
IFID_Write  output  1  IF/ID register load enable
IFID_Flush  output  1  clear IF/ID to NOP
IDEX_Write  output  1  ID/EX register load enable
IDEX_Bubble  output  1  load NOP into ID/EX instead of ID contents
EXMEM_Bubble  output  1  load NOP into EX/MEM
busy  output  1  FSM in MULDIV_BUSY
stall_count  output  CNT_W  cycles with PCWrite==0 since reset, saturating

Behaviour:
- Control outputs are combinational from state and inputs. busy and stall_count are registered.
- Default (no hazard): PCWrite=1, IFID_Write=1, IDEX_Write=1, IFID_Flush=0, IDEX_Bubble=0, EXMEM_Bubble=0.
- rst=1 (takes precedence over everything):
  - Outputs in that cycle: PCWrite=0, IFID_Write=0, IDEX_Write=0, IFID_Flush=1, IDEX_Bubble=1, EXMEM_Bubble=1.
  - At the edge: state<=RUN, cnt<=0, busy<=0, stall_count<=0.
  - Reset during MULDIV_BUSY aborts the sequence; the next cycle is RUN.
- Load-use hazard lu = EX_MemRead & (EX_rd!=0) & ((EX_rd==ID_rs) | (ID_uses_rt & EX_rd==ID_rt)).
- State RUN, priority branch_taken > EX_MulDiv > lu:
  - branch_taken: IFID_Flush=1, IDEX_Bubble=1, PC/IFID/IDEX writes remain 1. EX_MulDiv and lu are ignored this cycle. Stay in RUN.
  - EX_MulDiv with MULDIV_CYCLES>1:
    - PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1.
    - At the edge: state<=MULDIV_BUSY, cnt<=MULDIV_CYCLES-1.
  - EX_MulDiv with MULDIV_CYCLES==1: default outputs, stay in RUN.
  - lu: PCWrite=0, IFID_Write=0, IDEX_Bubble=1. IDEX_Write stays 1 so the bubble loads. Exactly one stall cycle results, because EX holds a NOP next cycle.
- State MULDIV_BUSY:
  - cnt>1: same freeze outputs as the RUN mul/div entry; cnt<=cnt-1.
  - cnt==1 (release cycle): default outputs, so the mul/div result advances to MEM; state<=RUN, cnt<=0.
  - branch_taken and lu are ignored in MULDIV_BUSY. EX holds the mul/div, so neither can legitimately occur there.
- Total EX occupancy of a mul/div is exactly MULDIV_CYCLES cycles. PCWrite=0 for MULDIV_CYCLES-1 of them.
- busy is registered (state==MULDIV_BUSY). It is 1 on cycles 2..MULDIV_CYCLES of a mul/div.
- stall_count increments at each edge where rst=0 and PCWrite=0. It holds at 2^CNT_W-1.
- Back-to-back mul/div: the release cycle advances, and the next cycle's RUN evaluation restarts the sequence with no gap.
- Register 0 never triggers lu.
- X on unused inputs while in MULDIV_BUSY must not affect outputs.

Test Plan:
1. Load-use: EX_MemRead=1, EX_rd=5, ID_rs=5 -> one cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next cycle (EX_MemRead=0) defaults; stall_count=1.
2. rt gating and $zero: EX_rd=7=ID_rt with ID_uses_rt=0 -> no stall. EX_rd=0=ID_rs with EX_MemRead=1 -> no stall. EX_rd=7=ID_rt with ID_uses_rt=1 -> stall.
3. Mul/div, MULDIV_CYCLES=4: EX_MulDiv=1 held -> PCWrite=0 for 3 cycles with EXMEM_Bubble=1; busy=1 on cycles 2-4; cycle 4 outputs default; stall_count=3.
4. Priority: branch_taken=1 with lu=1 -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, stall_count unchanged.
5. Reset mid-mul/div: rst=1 on cycle 2 of a 4-cycle op -> that cycle all writes 0 and all bubbles/flush 1; next cycle busy=0, stall_count=0, defaults.
6. Saturation with CNT_W=4: hold lu for 20 cycles -> stall_count stops at 15.
